// File: rtl/ras_pkg.sv
// Shared types and default sizing for the checkpointed return-address stack.
// Entry and checkpoint layouts below are at the default widths.
package ras_pkg;

   localparam int unsigned DefDepth = 16;
   localparam int unsigned DefPtrw  = 4;
   localparam int unsigned DefWidth = 32;
   localparam int unsigned DefCntw  = 7;
   localparam int unsigned DefNckpt = 4;
   localparam int unsigned DefCkptw = 2;

   typedef struct packed {
      logic [DefCntw-1:0]  rec_cnt;
      logic [DefWidth-1:0] addr;
   } ras_entry_t;

   typedef struct packed {
      logic [DefPtrw-1:0] top_ptr;
      logic [DefPtrw:0]   count;
      ras_entry_t         top;
   } ras_ckpt_t;

endpackage

// File: rtl/ras_ckpt_file.sv
// Checkpoint record file: NCKPT slots, one write port at an auto-advancing
// write pointer and one combinational read port.
module ras_ckpt_file
   import ras_pkg::*;
#(
   parameter int unsigned NCKPT = DefNckpt,
   parameter int unsigned CKPTW = DefCkptw,
   parameter int unsigned RECW  = $bits(ras_ckpt_t)
) (
   input  logic             Clk,
   input  logic             Rest,
   input  logic             WrValid,
   input  logic [RECW-1:0]  WrData,
   output logic [CKPTW-1:0] WrId,
   input  logic [CKPTW-1:0] RdId,
   output logic [RECW-1:0]  RdData
);

   localparam logic [CKPTW-1:0] LastId = CKPTW'(NCKPT - 1);

   logic [RECW-1:0]  slot_q [NCKPT];
   logic [CKPTW-1:0] wr_ptr_q, wr_ptr_d;

   // Explicit wrap so non-power-of-two slot counts still cycle correctly.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      if (WrValid) begin
         wr_ptr_d = (wr_ptr_q == LastId) ? '0 : wr_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge Clk) begin
      if (Rest) begin
         wr_ptr_q <= '0;
         slot_q   <= '{default: '0};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         if (WrValid) begin
            slot_q[wr_ptr_q] <= WrData;
         end
      end
   end

   assign WrId   = wr_ptr_q;
   assign RdData = slot_q[RdId];

endmodule

// File: rtl/ras_ckpt_stack.sv
// Return-address stack with recursion counters, circular overwrite on
// overflow, and checkpoint/restore of {TopPtr, Count, top entry}.
module ras_ckpt_stack
   import ras_pkg::*;
#(
   parameter int unsigned DEPTH = DefDepth,
   parameter int unsigned PTRW  = DefPtrw,
   parameter int unsigned WIDTH = DefWidth,
   parameter int unsigned CNTW  = DefCntw,
   parameter int unsigned NCKPT = DefNckpt,
   parameter int unsigned CKPTW = DefCkptw
) (
   input  logic             Clk,
   input  logic             Rest,
   input  logic             PushValid,
   input  logic [WIDTH-1:0] PushAddr,
   input  logic             PopValid,
   input  logic             CkptValid,
   output logic [CKPTW-1:0] CkptId,
   input  logic             RestoreValid,
   input  logic [CKPTW-1:0] RestoreId,
   output logic             TopValid,
   output logic [WIDTH-1:0] TopAddr,
   output logic [PTRW:0]    Count,
   output logic             Full,
   output logic             Empty,
   output logic             Overflow
);

   // Parameter-width mirrors of ras_entry_t / ras_ckpt_t.
   typedef struct packed {
      logic [CNTW-1:0]  rec_cnt;
      logic [WIDTH-1:0] addr;
   } ent_t;

   typedef struct packed {
      logic [PTRW-1:0] top_ptr;
      logic [PTRW:0]   count;
      ent_t            top;
   } ckpt_t;

   localparam int unsigned     RecW    = $bits(ckpt_t);
   localparam logic [PTRW:0]   FullCnt = (PTRW + 1)'(DEPTH);
   localparam logic [CNTW-1:0] RecOne  = CNTW'(1);
   localparam logic [CNTW-1:0] RecMax  = '1;

   ent_t            mem_q [DEPTH];
   ent_t            mem_d [DEPTH];
   logic [PTRW-1:0] top_ptr_q, top_ptr_d;
   logic [PTRW:0]   count_q, count_d;
   logic            ovf_q, ovf_d;

   ent_t            top_ent;
   logic            empty, full;
   logic [PTRW-1:0] ptr_inc, ptr_dec;
   ckpt_t           ckpt_wr, ckpt_rd;

   assign top_ent = mem_q[top_ptr_q];
   assign empty   = (count_q == '0);
   assign full    = (count_q == FullCnt);
   assign ptr_inc = top_ptr_q + 1'b1;
   assign ptr_dec = top_ptr_q - 1'b1;

   assign ckpt_wr = '{top_ptr: top_ptr_q, count: count_q, top: top_ent};

   ras_ckpt_file #(
      .NCKPT (NCKPT),
      .CKPTW (CKPTW),
      .RECW  (RecW)
   ) u_ckpt_file (
      .Clk     (Clk),
      .Rest    (Rest),
      .WrValid (CkptValid),
      .WrData  (ckpt_wr),
      .WrId    (CkptId),
      .RdId    (RestoreId),
      .RdData  (ckpt_rd)
   );

   always_comb begin
      mem_d     = mem_q;
      top_ptr_d = top_ptr_q;
      count_d   = count_q;
      ovf_d     = 1'b0;

      if (RestoreValid) begin
         top_ptr_d             = ckpt_rd.top_ptr;
         count_d               = ckpt_rd.count;
         mem_d[ckpt_rd.top_ptr] = ckpt_rd.top;
      end else if (PushValid && PopValid && !empty) begin
         mem_d[top_ptr_q] = '{rec_cnt: RecOne, addr: PushAddr};
      end else if (PushValid) begin
         if (!empty && (PushAddr == top_ent.addr) && (top_ent.rec_cnt != RecMax)) begin
            mem_d[top_ptr_q].rec_cnt = top_ent.rec_cnt + 1'b1;
         end else begin
            // When full, ptr_inc lands on the oldest entry, so the write overwrites it.
            top_ptr_d      = ptr_inc;
            mem_d[ptr_inc] = '{rec_cnt: RecOne, addr: PushAddr};
            if (full) begin
               ovf_d = 1'b1;
            end else begin
               count_d = count_q + 1'b1;
            end
         end
      end else if (PopValid && !empty) begin
         if (top_ent.rec_cnt > RecOne) begin
            mem_d[top_ptr_q].rec_cnt = top_ent.rec_cnt - 1'b1;
         end else begin
            mem_d[top_ptr_q] = '0;
            top_ptr_d        = ptr_dec;
            count_d          = count_q - 1'b1;
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Rest) begin
         mem_q     <= '{default: '0};
         top_ptr_q <= '0;
         count_q   <= '0;
         ovf_q     <= 1'b0;
      end else begin
         mem_q     <= mem_d;
         top_ptr_q <= top_ptr_d;
         count_q   <= count_d;
         ovf_q     <= ovf_d;
      end
   end

   assign TopValid = !empty;
   assign TopAddr  = empty ? '0 : top_ent.addr;
   assign Count    = count_q;
   assign Full     = full;
   assign Empty    = empty;
   assign Overflow = ovf_q;

endmodule
